// File: rtl/ro_puf_seq.sv
// ro_puf_seq -- measurement sequencer for the ring-oscillator PUF datapath.
//
// Walks RESP_BITS consecutive challenges starting at base_chall. For each
// challenge it runs the RO banks with the counters held clear (SETTLE cycles),
// opens the count gate (WINDOW cycles), waits one cycle for the comparator,
// then captures cmp_bit into the response word. The finished word is offered
// on a valid/ready handshake and retained after hand-off until the next start.
//
// Optional feature (macro RO_PUF_TIE_MASK_EN): adds cmp_eq input and a
// resp_mask output that records which challenges produced equal counts.
//
// Ports:
//   clk         system clock, rising edge
//   rst         asynchronous active-low reset
//   start       request a response (sampled in IDLE only)
//   base_chall  first challenge, latched on the accepted start
//   busy        high whenever not IDLE
//   ro_en       enable for both RO banks
//   cnt_clr     synchronous clear to both edge counters
//   cnt_en      count gate to both edge counters
//   chall       challenge driven to both muxes
//   cmp_bit     comparator result (count0 > count1)
//   cmp_eq      [macro] comparator tie flag (count0 == count1)
//   resp        response word, bit k from challenge base_chall+k
//   resp_mask   [macro] tie mask, bit k from challenge base_chall+k
//   resp_valid  resp complete and stable
//   resp_ready  consumer accepts resp

module ro_puf_seq #(
    parameter int RESP_BITS = 32,
    parameter int SETTLE    = 16,
    parameter int WINDOW    = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [7:0]           base_chall,
    output logic                 busy,
    output logic                 ro_en,
    output logic                 cnt_clr,
    output logic                 cnt_en,
    output logic [7:0]           chall,
    input  logic                 cmp_bit,
`ifdef RO_PUF_TIE_MASK_EN
    input  logic                 cmp_eq,
    output logic [RESP_BITS-1:0] resp_mask,
`endif
    output logic [RESP_BITS-1:0] resp,
    output logic                 resp_valid,
    input  logic                 resp_ready
);

    localparam int PH_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int IDX_W  = $clog2(RESP_BITS + 1);

    localparam logic [PH_W-1:0]  SETTLE_LAST = PH_W'(SETTLE - 1);
    localparam logic [PH_W-1:0]  WINDOW_LAST = PH_W'(WINDOW - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(RESP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_SETTLE  = 3'd1,
        S_COUNT   = 3'd2,
        S_WAIT    = 3'd3,
        S_CAPTURE = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [IDX_W-1:0]     idx_q,   idx_d;
    logic [7:0]           chall_q, chall_d;
    logic [RESP_BITS-1:0] resp_q,  resp_d;
`ifdef RO_PUF_TIE_MASK_EN
    logic [RESP_BITS-1:0] mask_q,  mask_d;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            phase_q <= '0;
            idx_q   <= '0;
            chall_q <= '0;
            resp_q  <= '0;
`ifdef RO_PUF_TIE_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            chall_q <= chall_d;
            resp_q  <= resp_d;
`ifdef RO_PUF_TIE_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        chall_d = chall_q;
        resp_d  = resp_q;
`ifdef RO_PUF_TIE_MASK_EN
        mask_d  = mask_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    chall_d = base_chall;
                    resp_d  = '0;
`ifdef RO_PUF_TIE_MASK_EN
                    mask_d  = '0;
`endif
                    idx_d   = '0;
                    phase_d = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (phase_q == SETTLE_LAST) begin
                    phase_d = '0;
                    state_d = S_COUNT;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            S_COUNT: begin
                if (phase_q == WINDOW_LAST) begin
                    phase_d = '0;
                    state_d = S_WAIT;
                end else begin
                    phase_d = phase_q + PH_W'(1);
                end
            end
            // One dead cycle so the last counted edge reaches the comparator.
            S_WAIT: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                // Decoded write keeps the index width independent of RESP_BITS.
                for (int i = 0; i < RESP_BITS; i++) begin
                    if (idx_q == IDX_W'(i)) begin
                        resp_d[i] = cmp_bit;
`ifdef RO_PUF_TIE_MASK_EN
                        mask_d[i] = cmp_eq;
`endif
                    end
                end
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    chall_d = chall_q + 8'd1;  // wraps FF -> 00
                    phase_d = '0;
                    state_d = S_SETTLE;
                end
            end
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from state so reset clears them immediately.
    // ------------------------------------------------------------------
    always_comb begin
        busy       = 1'b0;
        ro_en      = 1'b0;
        cnt_clr    = 1'b0;
        cnt_en     = 1'b0;
        resp_valid = 1'b0;
        chall      = 8'd0;
        case (state_q)
            S_SETTLE: begin
                busy    = 1'b1;
                ro_en   = 1'b1;
                cnt_clr = 1'b1;
                chall   = chall_q;
            end
            S_COUNT: begin
                busy   = 1'b1;
                ro_en  = 1'b1;
                cnt_en = 1'b1;
                chall  = chall_q;
            end
            S_WAIT, S_CAPTURE: begin
                busy  = 1'b1;
                ro_en = 1'b1;
                chall = chall_q;
            end
            S_DONE: begin
                busy       = 1'b1;
                resp_valid = 1'b1;
                chall      = chall_q;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    // Response is retained through IDLE until the next accepted start.
    assign resp = resp_q;
`ifdef RO_PUF_TIE_MASK_EN
    assign resp_mask = mask_q;
`endif

endmodule

// File: tb/tb_ro_puf_seq.sv
module tb_ro_puf_seq;

    localparam int RB = 4;
    localparam int ST = 2;
    localparam int WN = 8;
    localparam int P  = ST + WN + 2;
    localparam int N  = RB * P;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    base_chall = 8'd0;
    logic          busy, ro_en, cnt_clr, cnt_en, resp_valid;
    logic [7:0]    chall;
    logic          cmp_bit;
    logic [RB-1:0] resp;
    logic          resp_ready = 1'b0;
`ifdef RO_PUF_TIE_MASK_EN
    logic          cmp_eq;
    logic [RB-1:0] resp_mask;
`endif

    int errors = 0;
    int checks = 0;

    // Datapath stand-in: comparator results come from a per-run table indexed
    // by the offset of the current challenge from the run's base.
    logic [7:0]    cur_base = 8'd0;
    logic [RB-1:0] cmp_pat  = '0;
    logic [RB-1:0] eq_pat   = '0;
    logic [7:0]    off;
    assign off     = chall - cur_base;
    assign cmp_bit = cmp_pat[off[1:0]];

    logic [RB-1:0] exp_q[$];
    logic [RB-1:0] mexp_q[$];
    logic [RB-1:0] cur_exp;

    ro_puf_seq #(.RESP_BITS(RB), .SETTLE(ST), .WINDOW(WN)) dut (
        .clk(clk), .rst(rst), .start(start), .base_chall(base_chall),
        .busy(busy), .ro_en(ro_en), .cnt_clr(cnt_clr), .cnt_en(cnt_en),
        .chall(chall), .cmp_bit(cmp_bit),
`ifdef RO_PUF_TIE_MASK_EN
        .cmp_eq(cmp_eq), .resp_mask(resp_mask),
`endif
        .resp(resp), .resp_valid(resp_valid), .resp_ready(resp_ready)
    );

`ifdef RO_PUF_TIE_MASK_EN
    assign cmp_eq = eq_pat[off[1:0]];
`endif

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {busy, ro_en, cnt_clr, cnt_en, resp_valid, chall}
    function automatic logic [12:0] ctl_vec();
        return {busy, ro_en, cnt_clr, cnt_en, resp_valid, chall};
    endfunction

    // Called at a negedge; start goes high for the next edge (edge t).
    // start_at: cycle offset at which to pulse start again (0 = never).
    // rst_at:   cycle offset at which to assert reset and abort (0 = never).
    task automatic run_resp(input logic [7:0] base, input logic [RB-1:0] pat,
                            input logic [RB-1:0] mpat, input int start_at,
                            input int rst_at);
        logic [12:0] e;
        int          b, r;
        cur_base = base;
        cmp_pat  = pat;
        eq_pat   = mpat;
        if (rst_at == 0) begin
            exp_q.push_back(pat);
            mexp_q.push_back(mpat);
        end
        base_chall = base;
        start = 1'b1;
        tick();
        base_chall = ~base;  // must not affect a run already accepted
        for (int k = 1; k <= N; k++) begin
            start = (k == start_at);
            if (k == rst_at) begin
                rst = 1'b0;
                #1;
                check("async_reset_ctl", 64'(ctl_vec()), 64'd0);
                check("async_reset_resp", 64'(resp), 64'd0);
                tick();
                rst = 1'b1;
                start = 1'b0;
                return;
            end
            b = (k - 1) / P;
            r = (k - 1) % P;
            e = {1'b1, 1'b1, (r < ST), (r >= ST && r < ST + WN), 1'b0, 8'(base + 8'(b))};
            check($sformatf("ctl_k%0d", k), 64'(ctl_vec()), 64'(e));
            tick();
        end
        start = 1'b0;
        check("done_ctl", 64'(ctl_vec()), 64'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'(base + 8'(RB - 1))}));
    endtask

    // Scoreboard pop on resp_valid, hold check, then handshake.
    task automatic finish_resp(input int hold, input bit start_in_done);
        logic [RB-1:0] m;
        int            w;
        w = 0;
        while (!resp_valid && w < 5) begin
            tick();
            w++;
        end
        check("resp_valid_wait", 64'(resp_valid), 64'd1);
        cur_exp = exp_q.pop_front();
        m = mexp_q.pop_front();
        check("resp", 64'(resp), 64'(cur_exp));
`ifdef RO_PUF_TIE_MASK_EN
        check("resp_mask", 64'(resp_mask), 64'(m));
`endif
        resp_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            start = start_in_done && (i == 3);
            tick();
            check("hold", 64'({busy, resp_valid, resp}), 64'({1'b1, 1'b1, cur_exp}));
        end
        resp_ready = 1'b1;
        start = start_in_done;  // ignored on the handshake edge
        tick();
        resp_ready = 1'b0;
        start = 1'b0;
        check("idle_after_hs", 64'(ctl_vec()), 64'd0);
        check("resp_retained", 64'(resp), 64'(cur_exp));
        tick();
        check("still_idle", 64'(busy), 64'd0);
    endtask

    initial begin
        rst = 1'b0;
        tick();
        tick();
        check("reset_ctl", 64'(ctl_vec()), 64'd0);
        check("reset_resp", 64'(resp), 64'd0);
        rst = 1'b1;
        tick();
        check("idle_ctl", 64'(ctl_vec()), 64'd0);

        // 69..6C, bits 1,0,1,1; stray starts in COUNT and DONE.
        run_resp(8'h69, 4'b1101, 4'b0000, 5, 0);
        finish_resp(20, 1'b1);

        // Challenge wrap FE, FF, 00, 01.
        run_resp(8'hFE, 4'b0110, 4'b0000, 0, 0);
        finish_resp(2, 1'b0);

        // Reset in IDLE clears the retained response.
        rst = 1'b0;
        #1;
        check("idle_reset_resp", 64'(resp), 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // Reset in the 5th COUNT cycle of the first challenge, then a full run.
        run_resp(8'h30, 4'b1111, 4'b0000, 0, ST + 5);
        tick();
        check("post_reset_idle", 64'({ctl_vec(), resp}), 64'd0);
        run_resp(8'hA5, 4'b1010, 4'b0000, 0, 0);
        finish_resp(1, 1'b0);

`ifdef RO_PUF_TIE_MASK_EN
        run_resp(8'h10, 4'b0011, 4'b0100, 0, 0);
        finish_resp(1, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ro_puf_seq.md
# ro_puf_seq

Sequencer for the RO PUF measurement datapath: enables both ring-oscillator banks, clears and gates the two edge counters, steps the 8-bit challenge that drives both PUFmux256 selectors, and samples the comparator once per challenge. It accumulates RESP_BITS comparator results into a response word and hands it out on a valid/ready handshake. It replaces the fixed-challenge, free-running control in the PUF top and sits between the host-side requester and the RO/counter/comparator datapath.

## Interface
- RESP_BITS, 32: response width; one challenge is evaluated per bit; legal range 1..256.
- SETTLE, 16: cycles the ROs run with counters held clear before each count window; must be ≥1.
- WINDOW, 1024: cycles the counters are enabled per challenge; must be ≥1.
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request a response; sampled only in IDLE.
- base_chall  in  8  first challenge; latched on the accepted start.
- busy  out  1  high in every state except IDLE.
- ro_en  out  1  enables both RO banks.
- cnt_clr  out  1  synchronous clear to both counters.
- cnt_en  out  1  count gate, ANDed with the mux outputs at the counters.
- chall  out  8  challenge driven to both muxes.
- cmp_bit  in  1  comparator output, 1 when count0 > count1.
- resp  out  RESP_BITS  response word; bit k is the result for challenge base_chall+k.
- resp_valid  out  1  resp is complete and stable.
- resp_ready  in  1  consumer accepts resp.

## Operation
- States: IDLE, SETTLE, COUNT, WAIT, CAPTURE, DONE.
- IDLE: all outputs 0. start=1 latches base_chall into chall, clears resp and the bit index, and moves to SETTLE.
- SETTLE: ro_en=1, cnt_clr=1, cnt_en=0 for SETTLE cycles, then COUNT.
- COUNT: ro_en=1, cnt_en=1, cnt_clr=0 for WINDOW cycles, then WAIT.
- WAIT: one cycle with ro_en=1 and cnt_en=0, so the counters and comparator settle. Then CAPTURE.
- CAPTURE: one cycle. resp[index] <= cmp_bit.
  - If index == RESP_BITS-1, go to DONE.
  - Otherwise index+1, chall <= chall+1 (mod 256, 8'hFF wraps to 8'h00), and go to SETTLE.
- DONE: ro_en=0, cnt_en=0, resp_valid=1, resp held. When resp_valid & resp_ready, go to IDLE next cycle. resp is retained in IDLE until the next accepted start.
- start outside IDLE is ignored, including in DONE and on the return-to-IDLE cycle.
- base_chall changes after acceptance have no effect.
- Phase counter width: clog2(max(SETTLE,WINDOW)+1). Index width: clog2(RESP_BITS+1).
- Reset (rst=0, any state, including mid-window): immediately state=IDLE and all outputs 0, including resp, chall, resp_valid and the RESP_MASK outputs. The partial response is discarded.

## Timing
- Accepted start at edge t: SETTLE begins at cycle t+1 and cnt_clr is high in that cycle.
- Per-bit period: P = SETTLE + WINDOW + 2 cycles.
- resp_valid first high in cycle t+1+RESP_BITS·P.
- cnt_en is high for exactly WINDOW consecutive cycles per challenge.
- cnt_clr and cnt_en are never high in the same cycle.
- chall changes only at the CAPTURE→SETTLE edge. It is stable from the first SETTLE cycle through CAPTURE.
- cmp_bit is sampled in CAPTURE, at least one cycle after the last cnt_en cycle.
- The handshake completes in the cycle resp_valid & resp_ready are both high. resp_valid may stay high indefinitely.
- Minimum start-to-start interval: RESP_BITS·P + 2 cycles.

## Configuration
- Macro RO_PUF_TIE_MASK_EN.
- Defined:
  - Adds input cmp_eq (1: count0 == count1) and output resp_mask[RESP_BITS-1:0].
  - In CAPTURE, resp_mask[index] <= cmp_eq.
  - resp_mask follows the same validity, hold and reset rules as resp.
- Undefined: neither port exists, and ties resolve as cmp_bit (0).

## Test plan
- RESP_BITS=4, SETTLE=2, WINDOW=8, base_chall=8'h69, start pulse at cycle 0:
  - chall = 69, 6A, 6B, 6C in turn.
  - resp_valid first high at cycle 49.
  - Each cnt_en run is 8 cycles, preceded by 2 cycles of cnt_clr.
- Same config, cmp_bit driven 1,0,1,1 for challenges 0..3: resp=4'b1101. With resp_ready held 0 for 20 cycles, resp_valid and resp stay stable. resp_ready=1 for one cycle, then IDLE and busy=0.
- base_chall=8'hFE, RESP_BITS=4: chall sequence FE, FF, 00, 01.
- start pulsed during COUNT and during DONE: no restart. The timing of the current response is unchanged.
- rst asserted in the 5th cycle of a COUNT window: all outputs 0 asynchronously. After release, start gives a full, correct run.
- RO_PUF_TIE_MASK_EN defined, cmp_eq=1 on challenge 2 only: resp_mask=4'b0100.
